// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and the default datapath width.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/iter_muldiv_if.sv
// Request/response bundle between the execute stage and the muldiv unit.
// master = issuing pipeline side, slave = the muldiv unit.
interface iter_muldiv_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) ();

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/iter_muldiv_cond_negate.sv
// Conditional two's-complement negation, shared by operand magnitude
// extraction and the final sign correction.
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/iter_muldiv.sv
// Iterative RV32M unit: shift-add multiplier and restoring divider, one
// bit per cycle. Divider is built only when MULDIV_DIV_EN is defined.
module iter_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input logic          clk,
    input logic          reset,
    iter_muldiv_if.slave bus
);

    localparam int CW = $clog2(XLEN);

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nx;
    logic              neg_p;
    logic [XLEN-1:0]   res_q;

    logic              a_sgn;
    logic              b_sgn;
    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              last;
    logic              special;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] fix_in;
    logic [2*XLEN-1:0] fix_y;
    logic [XLEN-1:0]   fix_res;

    assign last = (cnt == CW'(XLEN - 1));

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.result    = res_q;

    // Decide which operands are signed for the requested op.
    always_comb begin
        a_sgn = (bus.op == OP_MUL) || (bus.op == OP_MULH) ||
                (bus.op == OP_MULHSU) || (bus.op == OP_DIV) ||
                (bus.op == OP_REM);
        b_sgn = (bus.op == OP_MUL) || (bus.op == OP_MULH) ||
                (bus.op == OP_DIV) || (bus.op == OP_REM);
        sa = a_sgn & bus.a[XLEN-1];
        sb = b_sgn & bus.b[XLEN-1];
    end

    cond_negate #(.WIDTH(XLEN)) u_neg_a (
        .neg (sa),
        .x   (bus.a),
        .y   (a_mag)
    );

    cond_negate #(.WIDTH(XLEN)) u_neg_b (
        .neg (sb),
        .x   (bus.b),
        .y   (b_mag)
    );

`ifdef MULDIV_DIV_EN
    localparam logic [XLEN-1:0] ONES    = '1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic              b_zero;
    logic              ovf;
    logic              neg_r;
    logic [XLEN:0]     div_trial;
    logic [XLEN-1:0]   rem_y;

    // Divide-by-zero and signed overflow resolve at accept.
    always_comb begin
        b_zero = (bus.b == '0);
        ovf = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
              (bus.a == MIN_NEG) && (bus.b == ONES);
        special = bus.op[2] && (b_zero || ovf);
        special_res = '0;
        if (b_zero) begin
            special_res = bus.op[1] ? bus.a : ONES;
        end else if (ovf) begin
            special_res = bus.op[1] ? '0 : bus.a;
        end
    end

    assign div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, mcand};

    cond_negate #(.WIDTH(XLEN)) u_neg_rem (
        .neg (neg_r),
        .x   (acc[2*XLEN-1:XLEN]),
        .y   (rem_y)
    );
`else
    assign special     = bus.op[2];
    assign special_res = '0;
`endif

    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} +
                     (acc[0] ? {1'b0, mcand} : '0);

    // One iteration: multiply shifts right, divide shifts left.
    always_comb begin
        acc_nx = {mul_sum, acc[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        if (op_q[2]) begin
            if (!div_trial[XLEN]) begin
                acc_nx = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_nx = {acc[2*XLEN-2:0], 1'b0};
            end
        end
`endif
    end

    // Quotient sits in the low half; upper half zeroed so the low half
    // of the wide negation is the negated quotient.
    assign fix_in = op_q[2] ? {{XLEN{1'b0}}, acc[XLEN-1:0]} : acc;

    cond_negate #(.WIDTH(2*XLEN)) u_neg_fix (
        .neg (neg_p),
        .x   (fix_in),
        .y   (fix_y)
    );

    // Pick the result half / remainder for the latched op.
    always_comb begin
        fix_res = fix_y[XLEN-1:0];
        if (!op_q[2] && (op_q != OP_MUL)) begin
            fix_res = fix_y[2*XLEN-1:XLEN];
        end
`ifdef MULDIV_DIV_EN
        if (op_q[2] && op_q[1]) begin
            fix_res = rem_y;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_nx = special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (last) begin
                    state_nx = ST_FIX;
                end
            end
            ST_FIX:  state_nx = ST_DONE;
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            op_q  <= '0;
            mcand <= '0;
            acc   <= '0;
            neg_p <= 1'b0;
            res_q <= '0;
`ifdef MULDIV_DIV_EN
            neg_r <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_q  <= bus.op;
                        neg_p <= sa ^ sb;
                        cnt   <= '0;
`ifdef MULDIV_DIV_EN
                        neg_r <= sa;
`endif
                        if (bus.op[2]) begin
                            mcand <= b_mag;
                            acc   <= {{XLEN{1'b0}}, a_mag};
                        end else begin
                            mcand <= a_mag;
                            acc   <= {{XLEN{1'b0}}, b_mag};
                        end
                        if (special) begin
                            res_q <= special_res;
                        end
                    end
                end
                ST_CALC: begin
                    acc <= acc_nx;
                    cnt <= last ? '0 : cnt + CW'(1);
                end
                ST_FIX:  res_q <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed-vector bench for iter_muldiv: table of ops with expected
// results and latencies, plus backpressure and mid-op reset sequences.
module tb_iter_muldiv;
    import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    iter_muldiv_if #(.XLEN(32)) bus ();

    iter_muldiv #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Called just after a negedge with the unit idle; returns just after
    // the negedge of cycle 1, with inputs scrambled.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op = ~op;
        bus.a = ~a;
        bus.b = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic retire(input string nm);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({nm, " in_ready after"}, {31'd0, bus.in_ready}, 32'd1);
        check({nm, " out_valid after"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    function automatic logic [31:0] dv(input logic [31:0] e);
        return DIV_ON ? e : 32'd0;
    endfunction

    function automatic int dl(input int l);
        return DIV_ON ? l : 1;
    endfunction

    vec_t vt[15];
    int   lat;

    initial begin
        n_cmp = 0;
        n_bad = 0;

        vt[0]  = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul 7*-3"};
        vt[1]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh min*min"};
        vt[2]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu max*max"};
        vt[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu"};
        vt[4]  = '{OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 34, "mul shift"};
        vt[5]  = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, "mulh -1*-1"};
        vt[6]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        dv(32'hFFFFFFFD), dl(34), "div -7/2"};
        vt[7]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        dv(32'hFFFFFFFF), dl(34), "rem -7/2"};
        vt[8]  = '{OP_DIVU,   32'd100,      32'd7,        dv(32'd14),       dl(34), "divu 100/7"};
        vt[9]  = '{OP_REMU,   32'd100,      32'd7,        dv(32'd2),        dl(34), "remu 100/7"};
        vt[10] = '{OP_DIVU,   32'hFFFFFFFF, 32'd1,        dv(32'hFFFFFFFF), dl(34), "divu max/1"};
        vt[11] = '{OP_DIVU,   32'h1234,     32'd0,        dv(32'hFFFFFFFF), 1,      "divu by 0"};
        vt[12] = '{OP_REM,    32'h1234,     32'd0,        dv(32'h1234),     1,      "rem by 0"};
        vt[13] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, dv(32'h80000000), 1,      "div ovf"};
        vt[14] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,            1,      "rem ovf"};

        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        #2;
        check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset result", bus.result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b);
            wait_valid(lat);
            check({vt[i].name, " latency"}, 32'(lat), 32'(vt[i].lat));
            check({vt[i].name, " result"}, bus.result, vt[i].exp);
            retire(vt[i].name);
        end

        // Backpressure: hold the result for 5 DONE cycles.
        issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_valid(lat);
        check("bp latency", 32'(lat), 32'd34);
        for (int k = 0; k < 5; k++) begin
            check("bp result", bus.result, 32'hFFFFFFFE);
            check("bp out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp busy", {31'd0, bus.busy}, 32'd1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp idle in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("bp idle busy", {31'd0, bus.busy}, 32'd0);
        check("bp result held", bus.result, 32'hFFFFFFFE);
        issue(OP_MUL, 32'd5, 32'd6);
        wait_valid(lat);
        check("b2b latency", 32'(lat), 32'd34);
        check("b2b result", bus.result, 32'd30);
        retire("b2b");

        // Reset in cycle 10 of a long operation.
        issue(DIV_ON ? OP_DIV : OP_MUL, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        check("pre-abort busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort result", bus.result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(OP_MUL, 32'd3, 32'd4);
        wait_valid(lat);
        check("post-reset latency", 32'(lat), 32'd34);
        check("post-reset result", bus.result, 32'd12);
        retire("post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
